// File: rtl/mem_port_arbiter.sv
// Shares one single-port synchronous RAM between the instruction-fetch and load/store ports.
// Data has priority; a saturating starvation counter forces a fetch grant after STARVE_LIMIT data wins.
module mem_port_arbiter #(
  parameter int MEM_SIZE     = 256,
  parameter int ADDR_BITS    = 8,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 instr_req,
  input  logic [31:0]          instr_addr,
  output logic                 instr_ack,
  output logic [31:0]          instr_rdata,
  input  logic                 data_req,
  input  logic                 data_we,
  input  logic [31:0]          data_addr,
  input  logic [31:0]          data_wdata,
  output logic                 data_ack,
  output logic [31:0]          data_rdata,
  output logic                 data_err,
  output logic                 stall,
  output logic                 ram_en,
  output logic                 ram_we,
  output logic [ADDR_BITS-1:0] ram_addr,
  output logic [31:0]          ram_wdata,
  input  logic [31:0]          ram_rdata
);

  typedef enum logic [1:0] {IDLE, RD_WAIT, RD_CAP, WR_ACK} state_t;

  state_t      state_q, state_d;
  logic        win_i_q, win_i_d;   // 1 = current transaction belongs to the fetch port
  logic        oor_q, oor_d;
  logic [3:0]  starve_q, starve_d;
  logic [31:0] ird_q, ird_d, drd_q, drd_d;
  logic        instr_oor, data_oor, grant_i, grant_d;
  logic [31:0] rd_val;

  assign instr_oor = instr_addr >= 32'(MEM_SIZE);
  assign data_oor  = data_addr  >= 32'(MEM_SIZE);
  assign grant_i   = instr_req & (~data_req | (starve_q == 4'(STARVE_LIMIT)));
  assign grant_d   = data_req & ~grant_i;
  assign rd_val    = oor_q ? 32'd0 : ram_rdata;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      win_i_q  <= 1'b0;
      oor_q    <= 1'b0;
      starve_q <= 4'd0;
      ird_q    <= 32'd0;
      drd_q    <= 32'd0;
    end else begin
      state_q  <= state_d;
      win_i_q  <= win_i_d;
      oor_q    <= oor_d;
      starve_q <= starve_d;
      ird_q    <= ird_d;
      drd_q    <= drd_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    win_i_d   = win_i_q;
    oor_d     = oor_q;
    starve_d  = starve_q;
    ird_d     = ird_q;
    drd_d     = drd_q;
    ram_en    = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_wdata = 32'd0;
    instr_ack = 1'b0;
    data_ack  = 1'b0;
    unique case (state_q)
      IDLE: begin
        // Reset also holds the RAM interface quiet even though requests may be high.
        if (!reset) begin
          if (grant_i) begin
            win_i_d  = 1'b1;
            oor_d    = instr_oor;
            ram_en   = ~instr_oor;
            ram_addr = instr_addr[ADDR_BITS-1:0];
            starve_d = 4'd0;
            state_d  = RD_WAIT;
          end else if (grant_d) begin
            win_i_d   = 1'b0;
            oor_d     = data_oor;
            ram_en    = ~data_oor;
            ram_we    = data_we & ~data_oor;
            ram_addr  = data_addr[ADDR_BITS-1:0];
            ram_wdata = data_wdata;
            if (!instr_req)                           starve_d = 4'd0;
            else if (starve_q != 4'(STARVE_LIMIT))    starve_d = starve_q + 4'd1;
            state_d   = data_we ? WR_ACK : RD_WAIT;
          end else begin
            starve_d = 4'd0;
          end
        end
      end
      RD_WAIT: begin
        if (win_i_q) ird_d = rd_val;
        else         drd_d = rd_val;
        state_d = RD_CAP;
      end
      RD_CAP: begin
        instr_ack = win_i_q;
        data_ack  = ~win_i_q;
        state_d   = IDLE;
      end
      WR_ACK: begin
        data_ack = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign data_err    = data_ack & oor_q;
  assign instr_rdata = ird_q;
  assign data_rdata  = drd_q;
  assign stall       = (instr_req & ~instr_ack) | (data_req & ~data_ack);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus randomized traffic
// checked against a word-array memory model and transaction-level ordering rules.
module tb_mem_port_arbiter;
  localparam int LIMIT = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        instr_req, data_req, data_we;
  logic [31:0] instr_addr, data_addr, data_wdata;
  logic        instr_ack, data_ack, data_err, stall;
  logic [31:0] instr_rdata, data_rdata;
  logic        ram_en, ram_we;
  logic [7:0]  ram_addr;
  logic [31:0] ram_wdata, ram_rdata;

  logic [31:0] ram   [0:255];
  logic [31:0] model [0:255];
  logic        pl_en;
  logic [7:0]  pl_addr;
  logic [31:0] pl_data;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  // RAM with a preload path so only this process writes the array.
  always @(posedge clk) begin
    if (pl_en) ram[pl_addr] <= pl_data;
    else if (ram_en) begin
      if (ram_we) ram[ram_addr] <= ram_wdata;
      else        ram_rdata     <= ram[ram_addr];
    end
  end

  mem_port_arbiter #(.MEM_SIZE(256), .ADDR_BITS(8), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .reset(reset),
    .instr_req(instr_req), .instr_addr(instr_addr), .instr_ack(instr_ack), .instr_rdata(instr_rdata),
    .data_req(data_req), .data_we(data_we), .data_addr(data_addr), .data_wdata(data_wdata),
    .data_ack(data_ack), .data_rdata(data_rdata), .data_err(data_err), .stall(stall),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  task automatic idle(input int n);
    instr_req = 1'b0; data_req = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1; pl_en = 1'b0;
    instr_req = 1'b0; data_req = 1'b0; data_we = 1'b0;
    instr_addr = 32'd0; data_addr = 32'd0; data_wdata = 32'd0;
    for (int i = 0; i < 256; i++) begin
      model[i] = (i == 212) ? 32'h8C01_0004 : (i == 10) ? 32'h1234_5678 : $urandom;
      @(negedge clk); pl_en = 1'b1; pl_addr = 8'(i); pl_data = model[i];
    end
    @(negedge clk); pl_en = 1'b0;
    instr_req = 1'b1; instr_addr = 32'd7; #1;
    n_chk++; if (ram_en !== 1'b0) begin n_fail++; $display("FAIL rst_ram_en got %b exp 0", ram_en); end
    n_chk++; if (ram_addr !== 8'd0) begin n_fail++; $display("FAIL rst_ram_addr got %0d exp 0", ram_addr); end
    n_chk++; if ({instr_ack, data_ack, data_err} !== 3'b000) begin n_fail++; $display("FAIL rst_acks got %b exp 000", {instr_ack, data_ack, data_err}); end
    n_chk++; if (instr_rdata !== 32'd0) begin n_fail++; $display("FAIL rst_irdata got %h exp 0", instr_rdata); end
    n_chk++; if (data_rdata !== 32'd0) begin n_fail++; $display("FAIL rst_drdata got %h exp 0", data_rdata); end
    n_chk++; if (dut.starve_q !== 4'd0) begin n_fail++; $display("FAIL rst_starve got %0d exp 0", dut.starve_q); end
    instr_req = 1'b0;
    @(negedge clk); reset = 1'b0;
    idle(2);
  endtask

  task automatic test_fetch();
    @(negedge clk); instr_req = 1'b1; instr_addr = 32'd212; #1;
    n_chk++; if ({ram_en, ram_we} !== 2'b10) begin n_fail++; $display("FAIL fetch_en got %b exp 10", {ram_en, ram_we}); end
    n_chk++; if (ram_addr !== 8'd212) begin n_fail++; $display("FAIL fetch_addr got %0d exp 212", ram_addr); end
    n_chk++; if (stall !== 1'b1) begin n_fail++; $display("FAIL fetch_stall_n got %b exp 1", stall); end
    @(negedge clk); #1;
    n_chk++; if ({instr_ack, stall, ram_en} !== 3'b010) begin n_fail++; $display("FAIL fetch_n1 ack/stall/en got %b exp 010", {instr_ack, stall, ram_en}); end
    @(negedge clk); #1;
    n_chk++; if ({instr_ack, stall} !== 2'b10) begin n_fail++; $display("FAIL fetch_n2 ack/stall got %b exp 10", {instr_ack, stall}); end
    n_chk++; if (instr_rdata !== model[212]) begin n_fail++; $display("FAIL fetch_rdata got %h exp %h", instr_rdata, model[212]); end
    instr_req = 1'b0;
    idle(1);
  endtask

  task automatic test_store_load();
    @(negedge clk); data_req = 1'b1; data_we = 1'b1; data_addr = 32'd5; data_wdata = 32'hDEAD_BEEF; #1;
    n_chk++; if ({ram_en, ram_we, ram_addr, ram_wdata} !== {2'b11, 8'd5, 32'hDEAD_BEEF}) begin n_fail++; $display("FAIL store_ram got %b %b %0d %h exp 1 1 5 deadbeef", ram_en, ram_we, ram_addr, ram_wdata); end
    @(negedge clk); #1;
    n_chk++; if ({data_ack, data_err, stall} !== 3'b100) begin n_fail++; $display("FAIL store_ack ack/err/stall got %b exp 100", {data_ack, data_err, stall}); end
    model[5] = 32'hDEAD_BEEF;
    data_req = 1'b0;
    @(negedge clk); data_req = 1'b1; data_we = 1'b0; #1;
    @(negedge clk); #1;
    n_chk++; if (data_ack !== 1'b0) begin n_fail++; $display("FAIL load_early_ack got %b exp 0", data_ack); end
    @(negedge clk); #1;
    n_chk++; if ({data_ack, data_err} !== 2'b10) begin n_fail++; $display("FAIL load_ack ack/err got %b exp 10", {data_ack, data_err}); end
    n_chk++; if (data_rdata !== model[5]) begin n_fail++; $display("FAIL load_rdata got %h exp %h", data_rdata, model[5]); end
    data_req = 1'b0;
    idle(1);
  endtask

  task automatic test_simultaneous();
    @(negedge clk);
    instr_req = 1'b1; instr_addr = 32'd212;
    data_req = 1'b1; data_we = 1'b0; data_addr = 32'd10; #1;
    n_chk++; if ({ram_en, ram_we, ram_addr} !== {2'b10, 8'd10}) begin n_fail++; $display("FAIL sim_first got %b %b %0d exp 1 0 10", ram_en, ram_we, ram_addr); end
    repeat (2) @(negedge clk); #1;
    n_chk++; if ({data_ack, instr_ack, stall} !== 3'b101) begin n_fail++; $display("FAIL sim_dack d/i/stall got %b exp 101", {data_ack, instr_ack, stall}); end
    n_chk++; if (data_rdata !== model[10]) begin n_fail++; $display("FAIL sim_drdata got %h exp %h", data_rdata, model[10]); end
    data_req = 1'b0;
    @(negedge clk); #1;
    n_chk++; if ({ram_en, ram_addr} !== {1'b1, 8'd212}) begin n_fail++; $display("FAIL sim_second got %b %0d exp 1 212", ram_en, ram_addr); end
    repeat (2) @(negedge clk); #1;
    n_chk++; if ({instr_ack, instr_rdata} !== {1'b1, model[212]}) begin n_fail++; $display("FAIL sim_iack got %b %h exp 1 %h", instr_ack, instr_rdata, model[212]); end
    instr_req = 1'b0;
    idle(1);
  endtask

  task automatic test_starvation();
    int order[$];
    int stv[$];
    int exp_o[6] = '{0, 0, 1, 0, 0, 1};
    int exp_s[6] = '{1, 2, 0, 1, 2, 0};
    idle(1);
    @(negedge clk);
    instr_req = 1'b1; instr_addr = 32'd212;
    data_req = 1'b1; data_we = 1'b0; data_addr = 32'd10;
    for (int c = 0; c < 60 && order.size() < 6; c++) begin
      @(negedge clk); #1;
      if (instr_ack) begin order.push_back(1); stv.push_back(int'(dut.starve_q)); end
      if (data_ack)  begin order.push_back(0); stv.push_back(int'(dut.starve_q)); end
    end
    n_chk++; if (order.size() != 6) begin n_fail++; $display("FAIL starve_count got %0d grants exp 6", order.size()); end
    for (int i = 0; i < 6 && i < order.size(); i++) begin
      n_chk++; if (order[i] != exp_o[i]) begin n_fail++; $display("FAIL starve_order[%0d] got %0d exp %0d (1=instr)", i, order[i], exp_o[i]); end
      n_chk++; if (stv[i] != exp_s[i]) begin n_fail++; $display("FAIL starve_cnt[%0d] got %0d exp %0d", i, stv[i], exp_s[i]); end
    end
    idle(2);
  endtask

  task automatic test_reset_mid_read();
    @(negedge clk); data_req = 1'b1; data_we = 1'b0; data_addr = 32'd5;
    @(negedge clk); reset = 1'b1; #1;
    n_chk++; if ({data_ack, ram_en} !== 2'b00) begin n_fail++; $display("FAIL rmid_ack_en got %b exp 00", {data_ack, ram_en}); end
    n_chk++; if ({instr_rdata, data_rdata} !== 64'd0) begin n_fail++; $display("FAIL rmid_rdata got %h %h exp 0 0", instr_rdata, data_rdata); end
    @(negedge clk); #1;
    n_chk++; if ({data_ack, ram_en} !== 2'b00) begin n_fail++; $display("FAIL rmid_hold got %b exp 00", {data_ack, ram_en}); end
    @(negedge clk); reset = 1'b0; #1;
    n_chk++; if ({ram_en, ram_we, ram_addr} !== {2'b10, 8'd5}) begin n_fail++; $display("FAIL rmid_regrant got %b %b %0d exp 1 0 5", ram_en, ram_we, ram_addr); end
    @(negedge clk); #1;
    n_chk++; if (data_ack !== 1'b0) begin n_fail++; $display("FAIL rmid_early got %b exp 0", data_ack); end
    @(negedge clk); #1;
    n_chk++; if ({data_ack, data_rdata} !== {1'b1, model[5]}) begin n_fail++; $display("FAIL rmid_ack got %b %h exp 1 %h", data_ack, data_rdata, model[5]); end
    data_req = 1'b0;
    idle(1);
  endtask

  task automatic test_out_of_range();
    logic en_seen;
    en_seen = 1'b0;
    @(negedge clk); data_req = 1'b1; data_we = 1'b0; data_addr = 32'd300; #1;
    en_seen |= ram_en;
    @(negedge clk); #1;
    en_seen |= ram_en;
    n_chk++; if ({data_ack, data_err} !== 2'b00) begin n_fail++; $display("FAIL oor_ld_early got %b exp 00", {data_ack, data_err}); end
    @(negedge clk); #1;
    en_seen |= ram_en;
    n_chk++; if (en_seen !== 1'b0) begin n_fail++; $display("FAIL oor_ld_ram_en got %b exp 0", en_seen); end
    n_chk++; if ({data_ack, data_err, data_rdata} !== {2'b11, 32'd0}) begin n_fail++; $display("FAIL oor_ld_ack got %b %b %h exp 1 1 0", data_ack, data_err, data_rdata); end
    data_req = 1'b0;
    @(negedge clk); data_req = 1'b1; data_we = 1'b1; data_addr = 32'd256; data_wdata = 32'hA5A5_5A5A; #1;
    n_chk++; if ({ram_en, ram_we} !== 2'b00) begin n_fail++; $display("FAIL oor_st_ram got %b exp 00", {ram_en, ram_we}); end
    @(negedge clk); #1;
    n_chk++; if ({data_ack, data_err} !== 2'b11) begin n_fail++; $display("FAIL oor_st_ack got %b exp 11", {data_ack, data_err}); end
    data_req = 1'b0;
    @(negedge clk); #1;
    n_chk++; if (ram[0] !== model[0]) begin n_fail++; $display("FAIL oor_st_alias ram0 got %h exp %h", ram[0], model[0]); end
    idle(1);
  endtask

  function automatic logic [31:0] rand_addr();
    int r;
    r = $urandom_range(0, 9);
    if (r == 0) return 32'd256 + 32'($urandom_range(0, 100));
    if (r == 1) return $urandom | 32'h0000_0100;
    return 32'($urandom_range(0, 15));
  endfunction

  task automatic test_random();
    bit ipend, dpend, dwe;
    int iwait, dwait, dstarve;
    logic [31:0] iad, dad, dwd, expv;
    ipend = 0; dpend = 0; iwait = 0; dwait = 0; dstarve = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk); #1;
      if (data_err && !data_ack) begin n_chk++; n_fail++; $display("FAIL rnd_err_without_ack"); end
      if (instr_ack) begin
        n_chk++;
        if (!ipend) begin n_fail++; $display("FAIL rnd_spurious_iack got 1 exp 0"); end
        else begin
          expv = (iad < 32'd256) ? model[iad[7:0]] : 32'd0;
          if (instr_rdata !== expv) begin n_fail++; $display("FAIL rnd_irdata addr %h got %h exp %h", iad, instr_rdata, expv); end
          n_chk++; if (dstarve > LIMIT + 1) begin n_fail++; $display("FAIL rnd_starve data_grants_while_waiting got %0d exp <= %0d", dstarve, LIMIT + 1); end
        end
        ipend = 0; instr_req = 1'b0;
      end
      if (data_ack) begin
        n_chk++;
        if (!dpend) begin n_fail++; $display("FAIL rnd_spurious_dack got 1 exp 0"); end
        else begin
          if (data_err !== (dad >= 32'd256)) begin n_fail++; $display("FAIL rnd_derr addr %h got %b exp %b", dad, data_err, dad >= 32'd256); end
          if (dwe) begin
            if (dad < 32'd256) model[dad[7:0]] = dwd;
          end else begin
            expv = (dad < 32'd256) ? model[dad[7:0]] : 32'd0;
            n_chk++; if (data_rdata !== expv) begin n_fail++; $display("FAIL rnd_drdata addr %h got %h exp %h", dad, data_rdata, expv); end
          end
          if (ipend) dstarve++;
        end
        dpend = 0; data_req = 1'b0;
      end
      if (ipend && ++iwait > 40) begin n_chk++; n_fail++; $display("FAIL rnd_itimeout addr %h", iad); ipend = 0; instr_req = 1'b0; end
      if (dpend && ++dwait > 40) begin n_chk++; n_fail++; $display("FAIL rnd_dtimeout addr %h", dad); dpend = 0; data_req = 1'b0; end
      if (!ipend && $urandom_range(0, 2) == 0) begin
        ipend = 1; iwait = 0; dstarve = 0; iad = rand_addr();
        instr_req = 1'b1; instr_addr = iad;
      end
      if (!dpend && $urandom_range(0, 1) == 0) begin
        dpend = 1; dwait = 0; dad = rand_addr(); dwe = $urandom_range(0, 1) == 1; dwd = $urandom;
        data_req = 1'b1; data_addr = dad; data_we = dwe; data_wdata = dwd;
      end
    end
    idle(4);
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_store_load();
    test_simultaneous();
    test_starvation();
    test_reset_mid_read();
    test_out_of_range();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port synchronous RAM between the core's instruction-fetch port and its load/store data port.
- Replaces the dual-port memory model so the core runs on a single block-RAM port.
- Produces the core stall (OR-ed into the core's stall alongside the UART stall).
- Data port has priority; a starvation guard guarantees fetch progress.

Parameters:
- MEM_SIZE, 256: RAM depth in 32-bit words; addresses are word indices.
- ADDR_BITS, 8: RAM address width; must equal ceil(log2(MEM_SIZE)).
- STARVE_LIMIT, 4: maximum consecutive data grants while a fetch waits; range 1..15.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- instr_req  in  1  fetch request; held with instr_addr until instr_ack.
- instr_addr  in  32  fetch word address.
- instr_ack  out  1  one-cycle pulse: instr_rdata valid.
- instr_rdata  out  32  fetched word, registered.
- data_req  in  1  load/store request; held with data_we, data_addr and data_wdata until data_ack.
- data_we  in  1  1 = store, 0 = load.
- data_addr  in  32  data word address.
- data_wdata  in  32  store data.
- data_ack  out  1  one-cycle pulse: load data valid or store done.
- data_rdata  out  32  load result, registered.
- data_err  out  1  pulses with data_ack when data_addr >= MEM_SIZE.
- stall  out  1  (instr_req & ~instr_ack) | (data_req & ~data_ack).
- ram_en  out  1  RAM access enable.
- ram_we  out  1  RAM write enable.
- ram_addr  out  ADDR_BITS  RAM address.
- ram_wdata  out  32  RAM write data.
- ram_rdata  in  32  RAM read data; valid the cycle after ram_en with ram_we=0.

Behaviour:
- Clock and reset: single clock domain, rising edge.
- Reset is asynchronous and active-high. On reset:
  - state = IDLE.
  - instr_ack, data_ack, data_err = 0.
  - instr_rdata, data_rdata = 0.
  - starvation counter = 0.
  - RAM outputs = 0.
- FSM states: IDLE, RD_WAIT, RD_CAP, WR_ACK.
- IDLE (arbitration):
  - Arbitration happens only in IDLE.
  - If only one request is present, that port wins.
  - If both are present, data wins unless starve_cnt == STARVE_LIMIT, in which case instr wins.
  - ram_en, ram_we, ram_addr and ram_wdata are driven combinationally from the winner in this cycle, so the RAM samples them at the end of the cycle.
  - Winner is instr, or data with we=0 -> RD_WAIT.
  - Winner is data with we=1 -> WR_ACK.
  - No request -> all RAM outputs 0; stay in IDLE.
- starve_cnt:
  - Increments on a data grant while instr_req=1.
  - Clears on an instr grant, or on any IDLE cycle with instr_req=0.
  - Saturates at STARVE_LIMIT.
- RD_WAIT: ram_en=0; the cycle of ram_rdata validity. Capture ram_rdata into the winner's rdata register at the cycle end -> RD_CAP.
- RD_CAP: pulse the winner's ack for this cycle -> IDLE.
- WR_ACK: pulse data_ack -> IDLE.
- Latency, with the request seen in IDLE at cycle N:
  - Read: ack at N+2; next arbitration at N+3.
  - Write: RAM written at end of N; ack at N+1; next arbitration at N+2.
  - A request arriving in a non-IDLE state waits for IDLE.
- Out of range (addr >= MEM_SIZE):
  - No RAM access: ram_en=0.
  - Read returns 0; write is dropped.
  - The FSM path and timing are unchanged.
  - data_err pulses with data_ack.
  - An out-of-range fetch returns 0 with no error signal; 0 decodes as a NOP (sll $0).
- ram_addr is addr[ADDR_BITS-1:0]; upper address bits are used only for the range check.
- rdata registers hold their value until the next read on that port.
- Request dropped before ack (protocol violation): the transaction still completes and the ack still pulses; the requester ignores it.
- stall is combinational. It deasserts in the ack cycle so the core advances its PC exactly once.
- Reset mid-transaction:
  - The transaction is abandoned and no ack is produced.
  - An interrupted write may or may not have reached RAM. It has reached RAM if reset came after the IDLE edge.
  - Requests still high after reset are re-arbitrated from IDLE.

Test Plan:
- Fetch only: ram holds 0x8C010004 at 212; instr_req with addr 212 at cycle N -> ram_en=1 and ram_addr=212 at N; instr_ack at N+2 with instr_rdata=0x8C010004; stall high N..N+1 and low at N+2.
- Store then load: data_we=1, addr 5, wdata 0xDEADBEEF -> data_ack at N+1. Then a load of addr 5 -> data_ack two cycles after the request, data_rdata=0xDEADBEEF, data_err=0.
- Simultaneous: instr 212 and data load 10 both requested at N -> data served first (ack N+2); instr re-arbitrated at N+3, ack N+5.
- Starvation with STARVE_LIMIT=2: instr_req held while data_req is re-asserted after every ack.
  - Grant order: D, D, I, D, D, I.
  - starve_cnt reads 1, 2, 0 around the first instr grant.
- Out of range: data load addr 300 -> ram_en stays 0, data_rdata=0, data_ack and data_err pulse together. Store to addr 256 -> no ram_we, data_err=1.
- Reset mid-read: assert reset in RD_WAIT -> no ack, outputs zeroed immediately. Release reset with req still high -> a fresh grant in the first IDLE cycle and a correct ack two cycles later.
